// File: rtl/poseidon_video_out.sv
`default_nettype none
// ============================================================================
//  Module   : poseidon_video_out
//  Purpose  : Board-side video output stage. Expands core colour to the VGA
//             and HDMI depths, delay-matches colour/sync/DE, normalises sync
//             polarity by measuring the incoming sync duty, and sequences the
//             HDMI transmitter reset.
//  Revision : 1.0  initial release
// ============================================================================
module poseidon_video_out #(
    parameter int IN_BITS    = 6,
    parameter int VGA_BITS   = 6,
    parameter int HDMI_BITS  = 8,
    parameter int PIPE       = 2,
    parameter int SYNC_POL   = 0,
    parameter int BLANK_ZERO = 1,
    parameter int RST_CYCLES = 1024
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [IN_BITS-1:0]   r_in,
    input  logic [IN_BITS-1:0]   g_in,
    input  logic [IN_BITS-1:0]   b_in,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 hblank,
    input  logic                 vblank,
    output logic [VGA_BITS-1:0]  VGA_R,
    output logic [VGA_BITS-1:0]  VGA_G,
    output logic [VGA_BITS-1:0]  VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic [HDMI_BITS-1:0] HDMI_R,
    output logic [HDMI_BITS-1:0] HDMI_G,
    output logic [HDMI_BITS-1:0] HDMI_B,
    output logic                 HDMI_HS,
    output logic                 HDMI_VS,
    output logic                 HDMI_DE,
    output logic                 HDMI_RST,
    output logic                 pol_locked
);

    localparam logic POL        = (SYNC_POL != 0);
    localparam logic BLANK_EN   = (BLANK_ZERO != 0);
    localparam int   RST_W      = $clog2(RST_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LIMIT = RST_W'(RST_CYCLES);

    // ------------------------------------------------------------------
    // Delay-matching pipeline
    // ------------------------------------------------------------------
    logic [IN_BITS-1:0] r_pipe [PIPE];
    logic [IN_BITS-1:0] g_pipe [PIPE];
    logic [IN_BITS-1:0] b_pipe [PIPE];
    logic [PIPE-1:0]    hs_pipe;
    logic [PIPE-1:0]    vs_pipe;
    logic [PIPE-1:0]    de_pipe;
    logic               de_raw;

    assign de_raw = ~(hblank | vblank);

    // Shift colour, sync and DE through PIPE stages; sync resets to the
    // inactive level of an active-low input so outputs start inactive.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE; i++) begin
                r_pipe[i] <= '0;
                g_pipe[i] <= '0;
                b_pipe[i] <= '0;
            end
            hs_pipe <= '1;
            vs_pipe <= '1;
            de_pipe <= '0;
        end else begin
            r_pipe[0]  <= r_in;
            g_pipe[0]  <= g_in;
            b_pipe[0]  <= b_in;
            hs_pipe[0] <= hs_in;
            vs_pipe[0] <= vs_in;
            de_pipe[0] <= de_raw;
            for (int i = 1; i < PIPE; i++) begin
                r_pipe[i]  <= r_pipe[i-1];
                g_pipe[i]  <= g_pipe[i-1];
                b_pipe[i]  <= b_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                de_pipe[i] <= de_pipe[i-1];
            end
        end
    end

    logic [IN_BITS-1:0] r_last;
    logic [IN_BITS-1:0] g_last;
    logic [IN_BITS-1:0] b_last;
    logic               de_last;
    logic               blank;

    assign r_last  = r_pipe[PIPE-1];
    assign g_last  = g_pipe[PIPE-1];
    assign b_last  = b_pipe[PIPE-1];
    assign de_last = de_pipe[PIPE-1];
    assign blank   = BLANK_EN && !de_last;

    // ------------------------------------------------------------------
    // Bit-replicating colour expansion (pure wiring)
    // ------------------------------------------------------------------
    logic [VGA_BITS-1:0]  vga_r_exp,  vga_g_exp,  vga_b_exp;
    logic [HDMI_BITS-1:0] hdmi_r_exp, hdmi_g_exp, hdmi_b_exp;

    for (genvar k = 0; k < VGA_BITS; k++) begin : g_vga_bits
        localparam int SRC = IN_BITS - 1 - ((VGA_BITS - 1 - k) % IN_BITS);
        assign vga_r_exp[k] = r_last[SRC];
        assign vga_g_exp[k] = g_last[SRC];
        assign vga_b_exp[k] = b_last[SRC];
    end

    for (genvar k = 0; k < HDMI_BITS; k++) begin : g_hdmi_bits
        localparam int SRC = IN_BITS - 1 - ((HDMI_BITS - 1 - k) % IN_BITS);
        assign hdmi_r_exp[k] = r_last[SRC];
        assign hdmi_g_exp[k] = g_last[SRC];
        assign hdmi_b_exp[k] = b_last[SRC];
    end

    assign VGA_R  = blank ? '0 : vga_r_exp;
    assign VGA_G  = blank ? '0 : vga_g_exp;
    assign VGA_B  = blank ? '0 : vga_b_exp;
    assign HDMI_R = blank ? '0 : hdmi_r_exp;
    assign HDMI_G = blank ? '0 : hdmi_g_exp;
    assign HDMI_B = blank ? '0 : hdmi_b_exp;
    assign HDMI_DE = de_last;

    // ------------------------------------------------------------------
    // Sync polarity measurement
    // ------------------------------------------------------------------
    logic        hs_d, vs_d;
    logic        hs_rise, vs_rise;
    logic [11:0] h_hi_cnt, h_lo_cnt;
    logic [9:0]  v_hi_cnt, v_lo_cnt;
    logic        h_act_low, v_act_low;
    logic        h_seen, v_seen;

    assign hs_rise = hs_in & ~hs_d;
    assign vs_rise = vs_in & ~vs_d;

    // Previous-cycle sync levels for edge detection; idle-high avoids a
    // spurious edge straight out of reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_d <= 1'b1;
            vs_d <= 1'b1;
        end else begin
            hs_d <= hs_in;
            vs_d <= vs_in;
        end
    end

    // HS: count high/low cycles per line; on each rising edge the longer
    // level is taken as the idle level, then both counts restart.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            h_hi_cnt  <= '0;
            h_lo_cnt  <= '0;
            h_act_low <= 1'b1;
            h_seen    <= 1'b0;
        end else if (hs_rise) begin
            if (h_hi_cnt > h_lo_cnt)
                h_act_low <= 1'b1;
            else if (h_lo_cnt > h_hi_cnt)
                h_act_low <= 1'b0;
            h_hi_cnt <= '0;
            h_lo_cnt <= '0;
            h_seen   <= 1'b1;
        end else if (hs_in) begin
            if (h_hi_cnt != 12'hFFF)
                h_hi_cnt <= h_hi_cnt + 12'd1;
        end else begin
            if (h_lo_cnt != 12'hFFF)
                h_lo_cnt <= h_lo_cnt + 12'd1;
        end
    end

    // VS: same scheme, counting lines (hs rising edges) instead of cycles.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            v_hi_cnt  <= '0;
            v_lo_cnt  <= '0;
            v_act_low <= 1'b1;
            v_seen    <= 1'b0;
        end else if (vs_rise) begin
            if (v_hi_cnt > v_lo_cnt)
                v_act_low <= 1'b1;
            else if (v_lo_cnt > v_hi_cnt)
                v_act_low <= 1'b0;
            v_hi_cnt <= '0;
            v_lo_cnt <= '0;
            v_seen   <= 1'b1;
        end else if (hs_rise) begin
            if (vs_in) begin
                if (v_hi_cnt != 10'h3FF)
                    v_hi_cnt <= v_hi_cnt + 10'd1;
            end else begin
                if (v_lo_cnt != 10'h3FF)
                    v_lo_cnt <= v_lo_cnt + 10'd1;
            end
        end
    end

    // Lock flag rises together with the later of the two first updates.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            pol_locked <= 1'b0;
        else if ((h_seen | hs_rise) & (v_seen | vs_rise))
            pol_locked <= 1'b1;
    end

    logic hs_out, vs_out;

    assign hs_out  = hs_pipe[PIPE-1] ^ ~(h_act_low ^ POL);
    assign vs_out  = vs_pipe[PIPE-1] ^ ~(v_act_low ^ POL);
    assign VGA_HS  = hs_out;
    assign HDMI_HS = hs_out;
    assign VGA_VS  = vs_out;
    assign HDMI_VS = vs_out;

    // ------------------------------------------------------------------
    // HDMI transmitter reset sequencer
    // ------------------------------------------------------------------
    logic [RST_W-1:0] rst_cnt;

    // Count cycles since reset release, stopping at the hold length.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            rst_cnt <= '0;
        else if (rst_cnt != RST_LIMIT)
            rst_cnt <= rst_cnt + 1'b1;
    end

    assign HDMI_RST = (rst_cnt == RST_LIMIT);

endmodule
`default_nettype wire

// File: tb/tb_poseidon_video_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poseidon_video_out
//  Purpose  : Self-checking bench for poseidon_video_out (6-bit core colour,
//             8-bit VGA/HDMI, active-high sync out) against a cycle-level
//             behavioural model of expansion, delay, blanking and polarity.
//  Revision : 1.0  initial release
// ============================================================================
module tb_poseidon_video_out;

    localparam int IN_BITS    = 6;
    localparam int OUT_BITS   = 8;
    localparam int PIPE       = 2;
    localparam int RST_CYCLES = 1024;

    logic                clk_sys = 1'b0;
    logic                reset_n = 1'b1;
    logic [IN_BITS-1:0]  r_in = '0, g_in = '0, b_in = '0;
    logic                hs_in = 1'b1, vs_in = 1'b1, hblank = 1'b0, vblank = 1'b0;
    logic [OUT_BITS-1:0] VGA_R, VGA_G, VGA_B, HDMI_R, HDMI_G, HDMI_B;
    logic                VGA_HS, VGA_VS, HDMI_HS, HDMI_VS, HDMI_DE, HDMI_RST, pol_locked;

    poseidon_video_out #(
        .IN_BITS(IN_BITS), .VGA_BITS(OUT_BITS), .HDMI_BITS(OUT_BITS), .PIPE(PIPE),
        .SYNC_POL(1), .BLANK_ZERO(1), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .hblank(hblank), .vblank(vblank),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .HDMI_R(HDMI_R), .HDMI_G(HDMI_G), .HDMI_B(HDMI_B), .HDMI_HS(HDMI_HS),
        .HDMI_VS(HDMI_VS), .HDMI_DE(HDMI_DE), .HDMI_RST(HDMI_RST), .pol_locked(pol_locked)
    );

    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int base  = 0;

    // Short history of applied inputs, indexed by cycle number
    logic [5:0] h_r [8];
    logic [5:0] h_g [8];
    logic [5:0] h_b [8];
    logic       h_hs [8];
    logic       h_vs [8];
    logic       h_de [8];

    // Behavioural polarity model
    bit m_hact_low, m_vact_low, m_hseen, m_vseen, m_locked, m_prev_hs, m_prev_vs;
    int m_hhi, m_hlo, m_vhi, m_vlo;

    // Colour expansion: repeat the input pattern MSB-first, keep the top 8 bits
    function automatic logic [7:0] exp_col(input logic [5:0] v, input logic de);
        logic [11:0] rep;
        rep = {v, v};
        return de ? rep[11:4] : 8'h00;
    endfunction

    // Active-high output: high exactly while the input sits at its active level
    function automatic logic exp_sync(input logic level, input bit act_low);
        return act_low ? (level == 1'b0) : (level == 1'b1);
    endfunction

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic model_reset();
        m_hact_low = 1'b1; m_vact_low = 1'b1;
        m_hseen = 1'b0; m_vseen = 1'b0; m_locked = 1'b0;
        m_prev_hs = 1'b1; m_prev_vs = 1'b1;
        m_hhi = 0; m_hlo = 0; m_vhi = 0; m_vlo = 0;
        base = cyc;
    endtask

    // Drive one cycle of input, record it and advance the reference model
    task automatic apply(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                         input logic hs, input logic vs, input logic hb, input logic vb);
        bit hrise, vrise;
        r_in = r; g_in = g; b_in = b; hs_in = hs; vs_in = vs; hblank = hb; vblank = vb;
        h_r[cyc % 8] = r; h_g[cyc % 8] = g; h_b[cyc % 8] = b;
        h_hs[cyc % 8] = hs; h_vs[cyc % 8] = vs; h_de[cyc % 8] = !(hb || vb);
        hrise = hs && !m_prev_hs;
        vrise = vs && !m_prev_vs;
        if (hrise) begin
            if (m_hhi > m_hlo) m_hact_low = 1'b1;
            else if (m_hlo > m_hhi) m_hact_low = 1'b0;
            m_hhi = 0; m_hlo = 0; m_hseen = 1'b1;
        end else if (hs) begin
            m_hhi = (m_hhi < 4095) ? m_hhi + 1 : 4095;
        end else begin
            m_hlo = (m_hlo < 4095) ? m_hlo + 1 : 4095;
        end
        if (vrise) begin
            if (m_vhi > m_vlo) m_vact_low = 1'b1;
            else if (m_vlo > m_vhi) m_vact_low = 1'b0;
            m_vhi = 0; m_vlo = 0; m_vseen = 1'b1;
        end else if (hrise) begin
            if (vs) m_vhi = (m_vhi < 1023) ? m_vhi + 1 : 1023;
            else    m_vlo = (m_vlo < 1023) ? m_vlo + 1 : 1023;
        end
        if (m_hseen && m_vseen) m_locked = 1'b1;
        m_prev_hs = hs;
        m_prev_vs = vs;
        cyc++;
    endtask

    task automatic test_reset();
        int low;
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({VGA_R, VGA_G, VGA_B, HDMI_R, HDMI_G, HDMI_B} !== 48'h0) begin
            fails++; $display("FAIL reset_colour got=%h exp=0", {VGA_R, VGA_G, VGA_B, HDMI_R, HDMI_G, HDMI_B});
        end
        tests++;
        if ({HDMI_DE, HDMI_RST, pol_locked} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl de/rst/lock got=%b exp=000", {HDMI_DE, HDMI_RST, pol_locked});
        end
        tests++;
        if ({HDMI_HS, HDMI_VS, VGA_HS, VGA_VS} !== 4'b0000) begin
            fails++; $display("FAIL reset_sync got=%b exp=0000", {HDMI_HS, HDMI_VS, VGA_HS, VGA_VS});
        end
        repeat (3) tick();
        reset_n = 1'b1;
        model_reset();
        low = 0;
        while (low < 1500) begin
            if (HDMI_RST === 1'b1) break;
            low++;
            apply(6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        tests++;
        if (low !== RST_CYCLES) begin
            fails++; $display("FAIL hdmi_rst_low_cycles got=%0d exp=%0d", low, RST_CYCLES);
        end
    endtask

    task automatic test_colour_expansion();
        int i;
        logic [7:0] er, eg, eb;
        tick();
        apply(6'h20, 6'h3F, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= PIPE + 1; j++) begin
            tick();
            tests++;
            if (j == PIPE) begin
                if ({VGA_R, HDMI_R, VGA_G, HDMI_G, VGA_B, HDMI_B} !== {8'h82, 8'h82, 8'hFF, 8'hFF, 8'h00, 8'h00}) begin
                    fails++; $display("FAIL expand_directed j=%0d got=%h exp=8282ffff0000", j,
                                      {VGA_R, HDMI_R, VGA_G, HDMI_G, VGA_B, HDMI_B});
                end
            end else begin
                if ({VGA_R, HDMI_R, VGA_G, HDMI_G, VGA_B, HDMI_B} !== 48'h0) begin
                    fails++; $display("FAIL expand_latency j=%0d got=%h exp=0", j,
                                      {VGA_R, HDMI_R, VGA_G, HDMI_G, VGA_B, HDMI_B});
                end
            end
            apply(6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        for (int n = 0; n < 300; n++) begin
            tick();
            if (cyc - base >= PIPE) begin
                i  = (cyc - PIPE) % 8;
                er = exp_col(h_r[i], h_de[i]);
                eg = exp_col(h_g[i], h_de[i]);
                eb = exp_col(h_b[i], h_de[i]);
                tests++;
                if ({VGA_R, VGA_G, VGA_B, HDMI_R, HDMI_G, HDMI_B} !== {er, eg, eb, er, eg, eb}) begin
                    fails++; $display("FAIL expand_random cyc=%0d got=%h exp=%h", cyc,
                                      {VGA_R, VGA_G, VGA_B, HDMI_R, HDMI_G, HDMI_B}, {er, eg, eb, er, eg, eb});
                end
                tests++;
                if (HDMI_DE !== h_de[i]) begin
                    fails++; $display("FAIL de_random cyc=%0d got=%b exp=%b", cyc, HDMI_DE, h_de[i]);
                end
            end
            apply(6'($urandom), 6'($urandom), 6'($urandom), 1'b1, 1'b1,
                  ($urandom % 8) == 0, ($urandom % 16) == 0);
        end
    endtask

    task automatic test_blanking();
        int i;
        logic [7:0] ec;
        for (int j = 0; j < PIPE + 5; j++) begin
            tick();
            if (j >= PIPE) begin
                i  = (cyc - PIPE) % 8;
                ec = (j - PIPE == 1) ? 8'h00 : 8'hFF;
                tests++;
                if ({HDMI_R, HDMI_G, HDMI_B, VGA_R, VGA_G, VGA_B} !== {6{ec}}) begin
                    fails++; $display("FAIL blank_colour j=%0d got=%h exp=%h", j,
                                      {HDMI_R, HDMI_G, HDMI_B, VGA_R, VGA_G, VGA_B}, {6{ec}});
                end
                tests++;
                if (HDMI_DE !== (j - PIPE != 1)) begin
                    fails++; $display("FAIL blank_de j=%0d got=%b exp=%b", j, HDMI_DE, (j - PIPE != 1));
                end
                tests++;
                if (HDMI_HS !== exp_sync(h_hs[i], m_hact_low) || HDMI_HS !== (j - PIPE == 1)) begin
                    fails++; $display("FAIL blank_hs_align j=%0d got=%b exp=%b", j, HDMI_HS, (j - PIPE == 1));
                end
            end
            apply(6'h3F, 6'h3F, 6'h3F, (j == 1) ? 1'b0 : 1'b1, 1'b1, j == 1, 1'b0);
        end
    endtask

    task automatic test_hsync_polarity(input bit active_high);
        int i, hi_count;
        logic act, lvl, eh, ev;
        hi_count = 0;
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < 4; l++) begin
                for (int c = 0; c < 800; c++) begin
                    tick();
                    if (cyc - base >= PIPE) begin
                        i  = (cyc - PIPE) % 8;
                        eh = exp_sync(h_hs[i], m_hact_low);
                        ev = exp_sync(h_vs[i], m_vact_low);
                        tests++;
                        if ({HDMI_HS, VGA_HS} !== {eh, eh}) begin
                            fails++; $display("FAIL hs_out pol=%0d cyc=%0d got=%b%b exp=%b", active_high,
                                              cyc, HDMI_HS, VGA_HS, eh);
                        end
                        tests++;
                        if ({HDMI_VS, VGA_VS} !== {ev, ev}) begin
                            fails++; $display("FAIL vs_out pol=%0d cyc=%0d got=%b%b exp=%b", active_high,
                                              cyc, HDMI_VS, VGA_VS, ev);
                        end
                        tests++;
                        if (pol_locked !== m_locked) begin
                            fails++; $display("FAIL pol_locked cyc=%0d got=%b exp=%b", cyc, pol_locked, m_locked);
                        end
                    end
                    if (f == 2 && l == 3 && HDMI_HS === 1'b1) hi_count++;
                    act = (c < 96);
                    lvl = active_high ? act : !act;
                    apply(6'($urandom), 6'($urandom), 6'($urandom), lvl, (l == 0) ? 1'b0 : 1'b1,
                          c >= 640, 1'b0);
                end
            end
        end
        tests++;
        if (hi_count !== 96) begin
            fails++; $display("FAIL hs_high_per_line pol=%0d got=%0d exp=96", active_high, hi_count);
        end
        tests++;
        if (pol_locked !== 1'b1) begin
            fails++; $display("FAIL pol_locked_final got=%b exp=1", pol_locked);
        end
    endtask

    task automatic test_saturation();
        int lv [6];
        int ln [6];
        int i;
        logic eh;
        lv = '{0, 1, 0, 1, 0, 1};
        ln = '{10, 2000, 5000, 100, 50, 60};
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < ln[s]; c++) begin
                tick();
                i  = (cyc - PIPE) % 8;
                eh = exp_sync(h_hs[i], m_hact_low);
                tests++;
                if (HDMI_HS !== eh) begin
                    fails++; $display("FAIL sat_hs seg=%0d cyc=%0d got=%b exp=%b", s, cyc, HDMI_HS, eh);
                end
                if (c == ln[s] - 1 && s == 3) begin
                    tests++;
                    if (HDMI_HS !== 1'b1) begin
                        fails++; $display("FAIL sat_lo_wins got=%b exp=1", HDMI_HS);
                    end
                end
                if (c == ln[s] - 1 && s == 5) begin
                    tests++;
                    if (HDMI_HS !== 1'b0) begin
                        fails++; $display("FAIL sat_counters_cleared got=%b exp=0", HDMI_HS);
                    end
                end
                apply(6'h15, 6'h2A, 6'h3F, lv[s][0], 1'b1, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_reset_midline();
        tests++;
        if (HDMI_RST !== 1'b1) begin
            fails++; $display("FAIL hdmi_rst_before_midreset got=%b exp=1", HDMI_RST);
        end
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({HDMI_R, HDMI_G, HDMI_B, VGA_R, VGA_G, VGA_B, HDMI_DE, HDMI_RST, pol_locked} !== 51'h0) begin
            fails++; $display("FAIL midreset_async got=%h_%b%b%b exp=0", {HDMI_R, HDMI_G, HDMI_B},
                              HDMI_DE, HDMI_RST, pol_locked);
        end
        tests++;
        if ({HDMI_HS, HDMI_VS} !== 2'b00) begin
            fails++; $display("FAIL midreset_sync got=%b exp=00", {HDMI_HS, HDMI_VS});
        end
        repeat (2) tick();
        reset_n = 1'b1;
        model_reset();
        for (int n = 0; n < 8; n++) begin
            apply(6'h3F, 6'h00, 6'h20, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        tests++;
        if ({HDMI_RST, pol_locked} !== 2'b00) begin
            fails++; $display("FAIL midreset_restart rst/lock got=%b exp=00", {HDMI_RST, pol_locked});
        end
        tests++;
        if ({HDMI_R, HDMI_G, HDMI_B} !== 24'hFF0082) begin
            fails++; $display("FAIL midreset_colour got=%h exp=ff0082", {HDMI_R, HDMI_G, HDMI_B});
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_colour_expansion();
        test_blanking();
        test_hsync_polarity(1'b0);
        test_hsync_polarity(1'b1);
        test_saturation();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
